forwarding_scoreboard: RTL and testbench

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

---
 rtl/forwarding_scoreboard.sv | 103 ++++++++++
 tb/tb_forwarding_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - in-flight destination scoreboard with forward select and load-use stall
module forwarding_scoreboard #(
  parameter int N          = 5,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 1,
  parameter int CW         = 16,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [N-1:0]         issue_rd,
  input  logic                 issue_we,
  input  logic                 issue_is_load,
  input  logic                 flush,
  input  logic [NSRC*N-1:0]    rs_add,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic [CW-1:0]        stall_count
);

  // Entry 0 is the youngest in-flight instruction; entries age by one slot per cycle.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [N-1:0]     rd_q [DEPTH];
  logic [N-1:0]     rd_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SELW-1:0]  src_sel [NSRC];
  logic [NSRC-1:0]  src_ld_hit;
  logic             capture;

  // Youngest-match search per source; scanning oldest-to-youngest lets the youngest hit win.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      src_sel[s]    = '0;
      src_ld_hit[s] = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid_q[i] && (rd_q[i] == rs_add[s*N +: N]) && (rs_add[s*N +: N] != '0)) begin
          src_sel[s]    = SELW'(i + 1);
          src_ld_hit[s] = ld_q[i] && (i < LOAD_STAGE);
        end
      end
    end
  end

  // Pack per-source selects and raise the load-use stall unless a flush is killing the pipe.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      fwd_sel[s*SELW +: SELW] = src_sel[s];
    end
    stall = (|src_ld_hit) && !flush;
  end

  assign capture     = issue_valid && issue_we && (issue_rd != '0) && !stall && !flush;
  assign stall_count = cnt_q;

  // Next state: shift the pipe, insert the issuing writer or a bubble, count stalls with saturation.
  always_comb begin
    valid_d  = '0;
    ld_d     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i] = rd_q[i];
    end
    valid_d[0] = capture;
    ld_d[0]    = capture && issue_is_load;
    rd_d[0]    = issue_rd;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      ld_d[i]    = ld_q[i-1];
      rd_d[i]    = rd_q[i-1];
    end
    if (flush) begin
      valid_d = '0;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards every in-flight entry and the stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - scoreboard-checked random and directed bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

  localparam int N          = 5;
  localparam int DEPTH      = 3;
  localparam int NSRC       = 2;
  localparam int LOAD_STAGE = 1;
  localparam int SELW       = $clog2(DEPTH + 1);
  localparam int SAT_CW     = 4;
  localparam int MAX16      = 65535;
  localparam int MAX4       = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_valid;
  logic [N-1:0]         issue_rd;
  logic                 issue_we;
  logic                 issue_is_load;
  logic                 flush;
  logic [N-1:0]         rs0, rs1;
  logic [NSRC*N-1:0]    rs_add;
  logic [NSRC*SELW-1:0] fwd_sel, fwd_sel_b;
  logic                 stall, stall_b;
  logic [15:0]          stall_count;
  logic [SAT_CW-1:0]    stall_count_b;

  assign rs_add = {rs1, rs0};

  always #5 clk = ~clk;

  forwarding_scoreboard #(.N(N), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_is_load(issue_is_load), .flush(flush), .rs_add(rs_add),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  forwarding_scoreboard #(.N(N), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE), .CW(SAT_CW)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_is_load(issue_is_load), .flush(flush), .rs_add(rs_add),
    .fwd_sel(fwd_sel_b), .stall(stall_b), .stall_count(stall_count_b)
  );

  // Reference model: list of in-flight writers, youngest first.
  typedef struct { bit v; int rd; bit ld; } ent_t;
  typedef struct { int sel0; int sel1; bit stl; int c16; int c4; } exp_t;

  ent_t pipe[$];
  int   cnt16, cnt4;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   driver_done = 0;

  function automatic void model_clear();
    ent_t e;
    e.v = 0; e.rd = 0; e.ld = 0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    cnt16 = 0;
    cnt4  = 0;
  endfunction

  // Index+1 of the youngest in-flight writer of register r, 0 when none (r0 never matches).
  function automatic int youngest(int r);
    if (r == 0) return 0;
    for (int i = 0; i < DEPTH; i++)
      if (pipe[i].v && pipe[i].rd == r) return i + 1;
    return 0;
  endfunction

  function automatic bit needs_stall(int hit);
    return (hit != 0) && pipe[hit-1].ld && (hit - 1 < LOAD_STAGE);
  endfunction

  task automatic step();
    exp_t e;
    ent_t n;
    if (rst) model_clear();
    e.sel0 = youngest(int'(rs0));
    e.sel1 = youngest(int'(rs1));
    e.stl  = (needs_stall(e.sel0) || needs_stall(e.sel1)) && !flush;
    e.c16  = cnt16;
    e.c4   = cnt4;
    exp_q.push_back(e);
    if (!rst) begin
      if (e.stl) begin
        if (cnt16 < MAX16) cnt16++;
        if (cnt4 < MAX4) cnt4++;
      end
      n.v  = issue_valid && issue_we && issue_rd != 0 && !e.stl && !flush;
      n.rd = int'(issue_rd);
      n.ld = issue_is_load;
      void'(pipe.pop_back());
      pipe.push_front(n);
      if (flush) foreach (pipe[i]) pipe[i].v = 0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit iv, input int rd, input bit we, input bit ld, input bit fl,
                       input int r0, input int r1, input bit r);
    issue_valid = iv; issue_rd = N'(rd); issue_we = we; issue_is_load = ld;
    flush = fl; rs0 = N'(r0); rs1 = N'(r1); rst = r;
    step();
  endtask

  task automatic bubble(input int r0, input int r1);
    drive(0, 0, 0, 0, 0, r0, r1, 0);
  endtask

  // Monitor: outputs are combinational, so one expected vector is due at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (int'(fwd_sel[0 +: SELW]) != e.sel0) begin
        miscompares++;
        $display("FAIL fwd_sel0 t=%0t got %0d want %0d", $time, fwd_sel[0 +: SELW], e.sel0);
      end
      if (int'(fwd_sel[SELW +: SELW]) != e.sel1) begin
        miscompares++;
        $display("FAIL fwd_sel1 t=%0t got %0d want %0d", $time, fwd_sel[SELW +: SELW], e.sel1);
      end
      if (stall != e.stl) begin
        miscompares++;
        $display("FAIL stall t=%0t got %0b want %0b", $time, stall, e.stl);
      end
      if (int'(stall_count) != e.c16) begin
        miscompares++;
        $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, e.c16);
      end
      if ({stall_b, fwd_sel_b} != {stall, fwd_sel}) begin
        miscompares++;
        $display("FAIL narrow_outputs t=%0t got %0b/%0h want %0b/%0h", $time, stall_b, fwd_sel_b, e.stl, {N'(e.sel1), N'(e.sel0)});
      end
      if (int'(stall_count_b) != e.c4) begin
        miscompares++;
        $display("FAIL stall_count_sat t=%0t got %0d want %0d", $time, stall_count_b, e.c4);
      end
    end
  end

  initial begin
    rst = 1; issue_valid = 0; issue_rd = '0; issue_we = 0; issue_is_load = 0;
    flush = 0; rs0 = '0; rs1 = '0;
    model_clear();
    @(posedge clk);
    #2;
    // Reset state, then ALU result aging through the pipe.
    drive(0, 0, 0, 0, 0, 5, 0, 1);
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    repeat (4) bubble(5, 0);
    // Load-use stall then forwarding from entry 1.
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    bubble(0, 7);
    bubble(0, 7);
    // Back-to-back writers of the same register: youngest wins.
    drive(1, 3, 1, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 3, 0);
    // Writes to r0 are never tracked.
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    bubble(0, 0);
    // Flush beats a pending stall and a simultaneous issue.
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    drive(1, 9, 1, 0, 1, 0, 7, 0);
    bubble(9, 7);
    // Fill the pipe, build up stalls, then reset asynchronously mid-cycle.
    repeat (5) begin
      drive(1, 4, 1, 1, 0, 0, 0, 0);
      bubble(4, 0);
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 0, 0, 0);
    drive(1, 6, 1, 0, 0, 1, 2, 0);
    drive(0, 0, 0, 0, 0, 1, 2, 1);
    bubble(1, 2);
    // Randomised traffic over a small register range so hazards are frequent.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(3) != 0,
            $urandom_range(2) == 0, $urandom_range(15) == 0,
            $urandom_range(7), $urandom_range(7), $urandom_range(60) == 0);
    end
    // Sustained load-use pairs drive the narrow counter into saturation.
    repeat (40) begin
      drive(1, 8, 1, 1, 0, 8, 0, 0);
    end
    bubble(0, 0);
    driver_done = 1;
  end

  initial begin
    int budget;
    wait (driver_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
